// File: rtl/systolic_result_collector_pkg.sv
// rtl/systolic_result_collector_pkg.sv - shared types and width helpers for the systolic result collector
package systolic_result_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MAX_DIM    = 4;

   function automatic int elem_width(input int dw);
      return 2 * dw;
   endfunction

   function automatic int row_width(input int dw, input int dim);
      return dim * 2 * dw;
   endfunction

   // Array fill, output skew and one result register.
   function automatic int settle_default(input int dim);
      return 3 * dim - 1;
   endfunction

endpackage

// File: rtl/systolic_result_collector_row_mux.sv
// rtl/systolic_result_collector_row_mux.sv - selects one captured row of the result buffer
module result_row_mux
   import systolic_result_collector_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_DIM    = DEF_MAX_DIM
)(
   input  logic [MAX_DIM*MAX_DIM*2*DATA_WIDTH-1:0] buf_data,
   input  logic [$clog2(MAX_DIM)-1:0]              row,
   output logic [MAX_DIM*2*DATA_WIDTH-1:0]         data
);

   localparam int ROW_W    = $clog2(MAX_DIM);
   localparam int ROW_BITS = row_width(DATA_WIDTH, MAX_DIM);

   always_comb begin
      data = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         if (row == ROW_W'(i)) data = buf_data[i*ROW_BITS +: ROW_BITS];
      end
   end

endmodule

// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - snapshots the systolic array result bus and drains it row by row
module systolic_result_collector
   import systolic_result_collector_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_DIM    = DEF_MAX_DIM,
   parameter int SETTLE     = settle_default(MAX_DIM)
)(
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    start,
   input  logic [$clog2(MAX_DIM):0]                cfg_dim,
   input  logic [MAX_DIM*MAX_DIM*2*DATA_WIDTH-1:0] result,
   output logic [MAX_DIM*2*DATA_WIDTH-1:0]         out_data,
   output logic [$clog2(MAX_DIM)-1:0]              out_row,
   output logic                                    out_valid,
   output logic                                    out_last,
   input  logic                                    out_ready,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    overrun
);

   localparam int ROW_W    = $clog2(MAX_DIM);
   localparam int DIM_W    = ROW_W + 1;
   localparam int ROW_BITS = row_width(DATA_WIDTH, MAX_DIM);
   localparam int CNT_W    = $clog2(SETTLE + 1);

   state_t                      state;
   logic [DIM_W-1:0]            dim_r;
   logic [CNT_W-1:0]            cnt;
   logic [MAX_DIM*ROW_BITS-1:0] buf_r;
   logic [ROW_BITS-1:0]         row_data;
   logic [ROW_W-1:0]            row_next;
   logic                        accept;

   assign accept   = out_valid & out_ready;
   assign row_next = out_row + ROW_W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         dim_r     <= '0;
         cnt       <= '0;
         buf_r     <= '0;
         out_row   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && state != ST_IDLE) overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_WAIT;
                  busy    <= 1'b1;
                  overrun <= 1'b0;
                  cnt     <= CNT_W'(SETTLE - 1);
                  // Out-of-range sizes fall back to the full array so the row index stays bounded.
                  if (cfg_dim == '0 || cfg_dim > DIM_W'(MAX_DIM)) dim_r <= DIM_W'(MAX_DIM);
                  else                                          dim_r <= cfg_dim;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  buf_r     <= result;
                  state     <= ST_DRAIN;
                  out_valid <= 1'b1;
                  out_row   <= '0;
                  out_last  <= (dim_r == DIM_W'(1));
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_DRAIN: begin
               if (accept) begin
                  if (out_last) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_row   <= '0;
                     done      <= 1'b1;
                  end else begin
                     out_row  <= row_next;
                     out_last <= ({1'b0, row_next} == dim_r - DIM_W'(1));
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   result_row_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_DIM    (MAX_DIM)
   ) u_row_mux (
      .buf_data (buf_r),
      .row      (out_row),
      .data     (row_data)
   );

   assign out_data = out_valid ? row_data : '0;

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - self-checking bench for systolic_result_collector
module tb_systolic_result_collector;

   localparam int DW     = 32;
   localparam int MD     = 4;
   localparam int SETTLE = 3 * MD - 1;
   localparam int EW     = 2 * DW;
   localparam int RW     = MD * EW;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [2:0]        cfg_dim;
   logic [MD*RW-1:0]  result;
   logic [RW-1:0]     out_data;
   logic [1:0]        out_row;
   logic              out_valid;
   logic              out_last;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic              overrun;

   int tests_run = 0;
   int failed    = 0;

   longint unsigned ma [MD][MD];
   longint unsigned mb [MD][MD];
   logic [EW-1:0]   exp_c [MD][MD];

   always #5 clk = ~clk;

   systolic_result_collector #(
      .DATA_WIDTH (DW),
      .MAX_DIM    (MD),
      .SETTLE     (SETTLE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cfg_dim   (cfg_dim),
      .result    (result),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: C = A x B, element (i,j) packed at (i*MD+j)*EW.
   function automatic void compute_product();
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin
            logic [EW-1:0] s;
            s = '0;
            for (int k = 0; k < MD; k++) s += EW'(ma[i][k] * mb[k][j]);
            exp_c[i][j] = s;
         end
   endfunction

   function automatic logic [MD*RW-1:0] pack_result();
      logic [MD*RW-1:0] r;
      r = '0;
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) r[(i*MD+j)*EW +: EW] = exp_c[i][j];
      return r;
   endfunction

   function automatic logic [RW-1:0] exp_row(input int i);
      logic [RW-1:0] r;
      r = '0;
      for (int j = 0; j < MD; j++) r[j*EW +: EW] = exp_c[i][j];
      return r;
   endfunction

   function automatic logic [MD*RW-1:0] rand_bus();
      logic [MD*RW-1:0] r;
      for (int k = 0; k < MD*RW/32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic load_spec_matrices();
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin
            ma[i][j] = longint'(i*MD + j + 1);
            mb[i][j] = longint'(i*MD + j + 1);
         end
      for (int j = 0; j < MD; j++) begin
         mb[0][j] = longint'(3 + j);
         mb[1][j] = longint'(5 + j);
      end
   endtask

   task automatic load_random_matrices();
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin
            ma[i][j] = longint'($urandom);
            mb[i][j] = longint'($urandom);
         end
   endtask

   // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready.
   // start_at >= 0 pulses start while that beat is presented; abort_after > 0 resets after that many beats.
   task automatic run_flow(input int dim_cfg, input int mode, input int start_at, input int abort_after);
      int            dim;
      int            beats;
      int            pat;
      bit            stalled;
      bit            pulsed;
      logic [RW-1:0] hold_data;
      logic [1:0]    hold_row;
      logic          hold_last;
      dim     = (dim_cfg == 0) ? MD : dim_cfg;
      beats   = 0;
      pat     = 0;
      stalled = 0;
      pulsed  = 0;
      compute_product();

      cfg_dim = 3'(dim_cfg);
      start   = 1'b1;
      tick();
      start   = 1'b0;
      cfg_dim = 3'($urandom_range(0, 7));
      tests_run++;
      if (busy !== 1'b1 || overrun !== 1'b0) begin
         failed++;
         $display("FAIL start_accept busy=%b overrun=%b required busy=1 overrun=0", busy, overrun);
      end

      for (int s = 0; s < SETTLE - 1; s++) begin
         tests_run++;
         if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL settle_valid cycle=%0d out_valid=%b required 0", s, out_valid);
         end
         result = rand_bus();
         tick();
      end
      result = pack_result();
      tick();
      result = rand_bus();
      tests_run++;
      if (out_valid !== 1'b1) begin
         failed++;
         $display("FAIL first_beat_latency out_valid=%b required 1", out_valid);
      end

      for (int cyc = 0; cyc < 200 && beats < dim; cyc++) begin
         if (stalled) begin
            tests_run++;
            if (out_data !== hold_data || out_row !== hold_row || out_last !== hold_last) begin
               failed++;
               $display("FAIL stall_stable row=%0d last=%b required row=%0d last=%b", out_row, out_last, hold_row, hold_last);
            end
         end
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== exp_row(beats) || out_row !== 2'(beats) ||
             out_last !== (beats == dim - 1) || done !== 1'b0) begin
            failed++;
            $display("FAIL beat%0d valid=%b row=%0d last=%b done=%b data=%h required valid=1 row=%0d last=%b done=0 data=%h",
                     beats, out_valid, out_row, out_last, done, out_data, beats, (beats == dim - 1), exp_row(beats));
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (pat % 4 == 0 || pat % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         pat++;
         if (start_at == beats && !pulsed) begin
            start  = 1'b1;
            pulsed = 1;
         end else begin
            start = 1'b0;
         end
         if (out_valid && out_ready) begin
            beats++;
            stalled = 0;
         end else begin
            stalled   = 1;
            hold_data = out_data;
            hold_row  = out_row;
            hold_last = out_last;
         end
         tick();
         if (abort_after > 0 && beats == abort_after) break;
      end
      start     = 1'b0;
      out_ready = 1'b0;

      if (abort_after > 0) begin
         reset = 1'b0;
         tick();
         reset = 1'b1;
         tests_run++;
         if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0 || out_row !== 2'd0) begin
            failed++;
            $display("FAIL abort_idle valid=%b busy=%b done=%b row=%0d required all 0", out_valid, busy, done, out_row);
         end
         tick();
         tests_run++;
         if (done !== 1'b0 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL abort_no_done done=%b valid=%b required 0 0", done, out_valid);
         end
         return;
      end

      tests_run++;
      if (beats != dim) begin
         failed++;
         $display("FAIL beat_count got=%0d required=%0d (timeout)", beats, dim);
      end
      tests_run++;
      if (done !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
         failed++;
         $display("FAIL done_pulse done=%b valid=%b last=%b required done=1 valid=0 last=0", done, out_valid, out_last);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         tests_run++;
         if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL post_done cycle=%0d done=%b busy=%b valid=%b required 0 0 0", k, done, busy, out_valid);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      reset = 1'b1;
      tests_run++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_row !== 2'd0 ||
          busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
         failed++;
         $display("FAIL reset_state valid=%b last=%b row=%0d busy=%b done=%b overrun=%b required all 0",
                  out_valid, out_last, out_row, busy, done, overrun);
      end
      reset = 1'b0;
      start = 1'b1;
      tick();
      reset = 1'b1;
      start = 1'b0;
      tick();
      tests_run++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         failed++;
         $display("FAIL reset_wins_start busy=%b valid=%b required 0 0", busy, out_valid);
      end
   endtask

   task automatic test_full_flow();
      load_spec_matrices();
      run_flow(0, 0, -1, 0);
   endtask

   task automatic test_backpressure();
      load_spec_matrices();
      run_flow(4, 1, -1, 0);
   endtask

   task automatic test_cfg_dim();
      load_spec_matrices();
      run_flow(2, 0, -1, 0);
      load_random_matrices();
      run_flow(1, 2, -1, 0);
   endtask

   task automatic test_overrun();
      load_spec_matrices();
      run_flow(4, 0, 1, 0);
      tests_run++;
      if (overrun !== 1'b1) begin
         failed++;
         $display("FAIL overrun_set overrun=%b required 1", overrun);
      end
      tick();
      tick();
      tests_run++;
      if (overrun !== 1'b1) begin
         failed++;
         $display("FAIL overrun_sticky overrun=%b required 1", overrun);
      end
      run_flow(3, 0, -1, 0);
   endtask

   task automatic test_reset_mid_drain();
      load_spec_matrices();
      run_flow(4, 0, -1, 2);
      load_random_matrices();
      run_flow(4, 0, -1, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         load_random_matrices();
         run_flow(int'($urandom_range(0, 4)), 2, -1, 0);
      end
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      cfg_dim   = 3'd0;
      out_ready = 1'b0;
      result    = '0;
      test_reset();
      test_full_flow();
      test_backpressure();
      test_cfg_dim();
      test_overrun();
      test_reset_mid_drain();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
